// File: rtl/ramp_mixer_if.sv
// Control and sample bus of ramp_mixer: per-channel waveform, enable and volume inputs,
// master gain, and the registered PWM sample with its valid/ramp status.
interface ramp_mixer_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned VOL_W  = 4,
   parameter int unsigned OUT_W  = 8
) ();
   logic                    sample_tick;
   logic [NUM_CH-1:0]       wave;
   logic [NUM_CH-1:0]       enable;
   logic [NUM_CH*VOL_W-1:0] vol_target;
   logic                    ramp_en;
   logic [1:0]              gain;
   logic [OUT_W-1:0]        mixout;
   logic                    out_valid;
   logic                    ramp_done;

   modport master (
      output sample_tick, wave, enable, vol_target, ramp_en, gain,
      input  mixout, out_valid, ramp_done
   );

   modport slave (
      input  sample_tick, wave, enable, vol_target, ramp_en, gain,
      output mixout, out_valid, ramp_done
   );
endinterface

// File: rtl/ramp_mixer.sv
// Multi-channel volume-ramped mixer: per-tick volume slew (stage 1), then sum, scale and
// saturating master gain into a registered PWM sample (stage 2).
module ramp_mixer #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned VOL_W  = 4,
   parameter int unsigned OUT_W  = 8
) (
   input logic         clk,
   input logic         rst_n,
   ramp_mixer_if.slave bus
);
   localparam int unsigned SUM_W  = VOL_W + ((NUM_CH > 1) ? $clog2(NUM_CH) : 1);
   // Wide enough for the scaled sum shifted by the largest gain without loss.
   localparam int unsigned WIDE_W = SUM_W + OUT_W + 3;
   localparam int unsigned SH_L   = (SUM_W <= OUT_W) ? (OUT_W - SUM_W) : 0;
   localparam int unsigned SH_R   = (SUM_W > OUT_W) ? (SUM_W - OUT_W) : 0;

   logic [NUM_CH-1:0][VOL_W-1:0] cur_q, cur_d, eff;
   logic [NUM_CH-1:0]            wave_q, wave_d;
   logic                         pend_q, pend_d;
   logic [OUT_W-1:0]             mixout_q, mixout_d;
   logic                         out_valid_q, out_valid_d;
   logic                         ramp_done_q, ramp_done_d;
   logic [WIDE_W-1:0]            sum, scaled, gained;

   // Disabled channels target zero so they fade out rather than cut.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         eff[i] = bus.enable[i] ? bus.vol_target[i*VOL_W +: VOL_W] : '0;
      end
   end

   always_comb begin
      cur_d       = cur_q;
      wave_d      = wave_q;
      pend_d      = bus.sample_tick;
      ramp_done_d = 1'b1;
      if (bus.sample_tick) begin
         wave_d = bus.wave;
         for (int i = 0; i < NUM_CH; i++) begin
            if (!bus.ramp_en) begin
               cur_d[i] = eff[i];
            end else if (cur_q[i] < eff[i]) begin
               cur_d[i] = cur_q[i] + VOL_W'(1);
            end else if (cur_q[i] > eff[i]) begin
               cur_d[i] = cur_q[i] - VOL_W'(1);
            end
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (cur_d[i] != eff[i]) begin
            ramp_done_d = 1'b0;
         end
      end
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (wave_q[i]) begin
            sum = sum + WIDE_W'(cur_q[i]);
         end
      end
      scaled      = (sum << SH_L) >> SH_R;
      gained      = scaled << bus.gain;
      mixout_d    = mixout_q;
      out_valid_d = pend_q;
      if (pend_q) begin
         mixout_d = (|gained[WIDE_W-1:OUT_W]) ? '1 : gained[OUT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_q       <= '0;
         wave_q      <= '0;
         pend_q      <= 1'b0;
         mixout_q    <= '0;
         out_valid_q <= 1'b0;
         ramp_done_q <= 1'b1;
      end else begin
         cur_q       <= cur_d;
         wave_q      <= wave_d;
         pend_q      <= pend_d;
         mixout_q    <= mixout_d;
         out_valid_q <= out_valid_d;
         ramp_done_q <= ramp_done_d;
      end
   end

   assign bus.mixout    = mixout_q;
   assign bus.out_valid = out_valid_q;
   assign bus.ramp_done = ramp_done_q;
endmodule

// File: tb/tb_ramp_mixer.sv
// Bench for ramp_mixer: three parameterisations driven side by side, checked each cycle
// against an arithmetic model plus fixed expected values for the directed scenarios.
module tb_ramp_mixer;
   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick, ramp_en;
   logic [1:0] gain;
   logic [7:0]  wave_t [NI];
   logic [7:0]  en_t   [NI];
   logic [63:0] vt_t   [NI];
   logic [7:0]  mix_o  [NI];
   logic        ov_o   [NI];
   logic        done_o [NI];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ramp_mixer_if #(.NUM_CH(4), .VOL_W(4), .OUT_W(8)) if0 ();
   ramp_mixer_if #(.NUM_CH(1), .VOL_W(8), .OUT_W(8)) if1 ();
   ramp_mixer_if #(.NUM_CH(8), .VOL_W(4), .OUT_W(8)) if2 ();

   assign if0.sample_tick = tick;
   assign if0.ramp_en     = ramp_en;
   assign if0.gain        = gain;
   assign if0.wave        = wave_t[0][3:0];
   assign if0.enable      = en_t[0][3:0];
   assign if0.vol_target  = vt_t[0][15:0];
   assign if1.sample_tick = tick;
   assign if1.ramp_en     = ramp_en;
   assign if1.gain        = gain;
   assign if1.wave        = wave_t[1][0:0];
   assign if1.enable      = en_t[1][0:0];
   assign if1.vol_target  = vt_t[1][7:0];
   assign if2.sample_tick = tick;
   assign if2.ramp_en     = ramp_en;
   assign if2.gain        = gain;
   assign if2.wave        = wave_t[2];
   assign if2.enable      = en_t[2];
   assign if2.vol_target  = vt_t[2][31:0];

   assign mix_o[0] = if0.mixout;
   assign mix_o[1] = if1.mixout;
   assign mix_o[2] = if2.mixout;
   assign ov_o[0]  = if0.out_valid;
   assign ov_o[1]  = if1.out_valid;
   assign ov_o[2]  = if2.out_valid;
   assign done_o[0] = if0.ramp_done;
   assign done_o[1] = if1.ramp_done;
   assign done_o[2] = if2.ramp_done;

   ramp_mixer #(.NUM_CH(4), .VOL_W(4), .OUT_W(8)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   ramp_mixer #(.NUM_CH(1), .VOL_W(8), .OUT_W(8)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   ramp_mixer #(.NUM_CH(8), .VOL_W(4), .OUT_W(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   // Model state: channel volumes, the sum launched by the last tick, expected outputs.
   int cur_m   [NI][8];
   bit pend_m  [NI];
   int psum_m  [NI];
   int exp_mix [NI];
   bit exp_ov  [NI];

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int nch_of(input int k);
      return (k == 0) ? 4 : ((k == 1) ? 1 : 8);
   endfunction

   function automatic int vw_of(input int k);
      return (k == 1) ? 8 : 4;
   endfunction

   function automatic int eff_of(input int k, input int i);
      logic [63:0] v;
      if (!en_t[k][i]) return 0;
      v = (vt_t[k] >> (i * vw_of(k))) & ((64'd1 << vw_of(k)) - 64'd1);
      return int'(v);
   endfunction

   function automatic int scale_of(input int k, input int sum, input int g_sh);
      int sumw, scaled, g;
      sumw   = vw_of(k) + ((nch_of(k) > 1) ? $clog2(nch_of(k)) : 1);
      scaled = (sumw <= 8) ? (sum << (8 - sumw)) : (sum >> (sumw - 8));
      g      = scaled << g_sh;
      return (g > 255) ? 255 : g;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         for (int i = 0; i < 8; i++) cur_m[k][i] = 0;
         pend_m[k]  = 1'b0;
         psum_m[k]  = 0;
         exp_mix[k] = 0;
         exp_ov[k]  = 1'b0;
      end
   endtask

   // Advance one clock, update the model with the inputs seen at that edge, compare all.
   task automatic cycle();
      bit dn;
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         if (!rst_n) begin
            model_reset();
         end else begin
            exp_ov[k] = pend_m[k];
            if (pend_m[k]) exp_mix[k] = scale_of(k, psum_m[k], int'(gain));
            pend_m[k] = tick;
            if (tick) begin
               psum_m[k] = 0;
               for (int i = 0; i < nch_of(k); i++) begin
                  if (!ramp_en) cur_m[k][i] = eff_of(k, i);
                  else if (cur_m[k][i] < eff_of(k, i)) cur_m[k][i]++;
                  else if (cur_m[k][i] > eff_of(k, i)) cur_m[k][i]--;
                  if (wave_t[k][i]) psum_m[k] += cur_m[k][i];
               end
            end
         end
         dn = 1'b1;
         if (rst_n) begin
            for (int i = 0; i < nch_of(k); i++) if (cur_m[k][i] != eff_of(k, i)) dn = 1'b0;
         end
         check_eq($sformatf("mix%0d", k), mix_o[k], exp_mix[k]);
         check_eq($sformatf("valid%0d", k), ov_o[k], exp_ov[k]);
         check_eq($sformatf("done%0d", k), done_o[k], dn);
      end
   endtask

   task automatic tick_once();
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      cycle();
   endtask

   task automatic randomize_inputs();
      for (int k = 0; k < NI; k++) begin
         wave_t[k] = 8'($urandom);
         en_t[k]   = 8'($urandom);
         vt_t[k]   = {$urandom, $urandom};
      end
   endtask

   initial begin
      int cnt;
      tick    = 1'b0;
      ramp_en = 1'b0;
      gain    = 2'd0;
      for (int k = 0; k < NI; k++) begin
         wave_t[k] = '0;
         en_t[k]   = '0;
         vt_t[k]   = '0;
      end
      model_reset();
      #12;
      for (int k = 0; k < NI; k++) begin
         check_eq("rst_mix", mix_o[k], 0);
         check_eq("rst_valid", ov_o[k], 0);
         check_eq("rst_done", done_o[k], 1);
      end
      rst_n = 1'b1;
      cycle();

      // Jump mode, single channel at full volume.
      en_t[0] = 8'h1; vt_t[0] = 64'hF; wave_t[0] = 8'h1;
      tick_once();
      check_eq("jump_mix", mix_o[0], 60);
      check_eq("jump_valid", ov_o[0], 1);
      check_eq("jump_done", done_o[0], 1);

      en_t[0] = 8'hF; vt_t[0] = 64'hFFFF; wave_t[0] = 8'hF;
      tick_once();
      check_eq("all4_mix", mix_o[0], 240);
      gain = 2'd1;
      tick_once();
      check_eq("sat_mix", mix_o[0], 255);

      // Ramp up 0 -> 10 then fade out through disable.
      gain = 2'd0; en_t[0] = 8'h1; vt_t[0] = 64'h0; wave_t[0] = 8'h1;
      tick_once();
      ramp_en = 1'b1; vt_t[0] = 64'd10;
      for (int n = 1; n <= 12; n++) begin
         tick_once();
         check_eq("up_mix", mix_o[0], ((n < 10) ? n : 10) * 4);
         check_eq("up_done", done_o[0], (n >= 10) ? 1 : 0);
      end
      en_t[0] = 8'h0;
      for (int n = 1; n <= 10; n++) begin
         tick_once();
         check_eq("down_mix", mix_o[0], (10 - n) * 4);
      end

      // Back-to-back ticks.
      cnt = 0;
      tick = 1'b1;
      for (int c = 0; c <= 20; c++) begin
         cycle();
         if (c == 19) tick = 1'b0;
         if (ov_o[0]) cnt++;
         randomize_inputs();
         ramp_en = 1'($urandom);
         gain    = 2'($urandom);
      end
      check_eq("burst_count", cnt, 20);

      // Asynchronous reset in the middle of a burst.
      tick = 1'b1;
      repeat (5) cycle();
      #3 rst_n = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) begin
         check_eq("arst_mix", mix_o[k], 0);
         check_eq("arst_valid", ov_o[k], 0);
         check_eq("arst_done", done_o[k], 1);
      end
      cycle();
      tick = 1'b0;
      #3 rst_n = 1'b1;
      cnt = 0;
      repeat (3) begin
         cycle();
         if (ov_o[0]) cnt++;
      end
      check_eq("post_rst_valid", cnt, 0);

      // Random traffic across all three parameterisations.
      for (int c = 0; c < 500; c++) begin
         tick = ($urandom % 4) != 0;
         for (int k = 0; k < NI; k++) wave_t[k] = 8'($urandom);
         if ($urandom % 8 == 0) begin
            randomize_inputs();
            ramp_en = 1'($urandom);
            gain    = 2'($urandom);
         end
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ramp_mixer.md
RAMP_MIXER -- requirements
Module: ramp_mixer

Interface
REQ-001 Parameter NUM_CH, default 4, number of square/noise channels; legal range 1..8.
REQ-002 Parameter VOL_W, default 4, per-channel volume width in bits; legal range 2..8.
REQ-003 Parameter OUT_W, default 8, mixer output width feeding the PWM; SHALL be >= VOL_W.
REQ-004 Derived SUM_W = VOL_W + clog2(NUM_CH) (min VOL_W+1), internal sum width; not overridable.
REQ-005 clk  input  1  system clock; single clock domain.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 sample_tick  input  1  one-cycle strobe; advances ramps and launches one mix sample.
REQ-008 wave  input  NUM_CH  per-channel 1-bit waveform (square or LFSR bit), bit i = channel i.
REQ-009 enable  input  NUM_CH  per-channel enable; bit i = channel i.
REQ-010 vol_target  input  NUM_CH*VOL_W  packed target volumes, channel i at bits [i*VOL_W +: VOL_W].
REQ-011 ramp_en  input  1  1 = volumes slew one LSB per tick; 0 = volumes jump to target.
REQ-012 gain  input  2  master gain, left shift 0..3 applied after scaling, saturating.
REQ-013 mixout  output  OUT_W  registered mix sample for PWM.
REQ-014 out_valid  output  1  one-cycle pulse, mixout updated this cycle.
REQ-015 ramp_done  output  1  registered; 1 when every channel's current volume equals its effective target.

Function
REQ-016 Effective target eff[i] SHALL be vol_target[i] when enable[i]=1, else 0 (disable fades out, not cuts).
REQ-017 Each channel SHALL hold a VOL_W-bit current volume cur[i], changed only on clk edges with sample_tick=1.
REQ-018 On tick with ramp_en=1: cur[i] < eff[i] -> cur[i]+1; cur[i] > eff[i] -> cur[i]-1; equal -> hold; never overshoots, never wraps.
REQ-019 On tick with ramp_en=0: cur[i] <= eff[i] in one step.
REQ-020 Stage 1 (edge with tick, cycle T): cur[] updated per REQ-018/019 and wave_q <= wave captured simultaneously.
REQ-021 Stage 2 (edge T+1): sum = Σ over i of (wave_q[i] ? cur[i] : 0), SUM_W bits, no overflow by construction; cur[] used is the value written at edge T.
REQ-022 Scaling: if SUM_W <= OUT_W, scaled = sum << (OUT_W-SUM_W); else scaled = sum >> (SUM_W-OUT_W) (truncate LSBs).
REQ-023 Gain: g = scaled << gain computed wide; mixout <= all-ones (2^OUT_W-1) if g >= 2^OUT_W, else g[OUT_W-1:0]; written at edge T+1.
REQ-024 out_valid SHALL be 1 exactly in the cycle after edge T+1 (one pulse per tick); latency tick-to-out_valid = 1 cycle after the tick cycle.
REQ-025 mixout SHALL hold its value between samples.
REQ-026 Back-to-back ticks (every cycle) SHALL be supported: one sample per cycle, out_valid continuously high, no dropped samples.
REQ-027 ramp_done SHALL be updated each clk edge from post-update cur[] vs current eff[]; a target change mid-ramp redirects the ramp from the present cur[i] on the next tick.
REQ-028 enable, vol_target, gain, ramp_en changes without a tick SHALL not alter cur[] or mixout.

Reset
REQ-029 rst_n=0 SHALL asynchronously force cur[]=0, wave_q=0, mixout=0, out_valid=0, ramp_done=1, regardless of clk.
REQ-030 Reset mid-ramp or mid-pipeline SHALL discard the in-flight sample; first out_valid after release requires a new tick.
REQ-031 After rst_n deassertion, first tick SHALL ramp from 0 (ramp_en=1) or jump (ramp_en=0).

Verification
REQ-032 Defaults, ramp_en=0, ch0 enabled vol 15, wave=0001, gain=0, tick -> next cycle out_valid=1, mixout=60 (15<<2); ramp_done=1.
REQ-033 All 4 ch enabled vol 15, wave=1111, gain=0 -> mixout=240; gain=1 -> mixout=255 (saturated).
REQ-034 ramp_en=1, ch0 target 0->10, wave=0001, 12 ticks -> mixout sequence 4,8,...,40,40,40; ramp_done 0 until tenth tick, then 1.
REQ-035 ramp_en=1, ch0 at 10, enable[0] drops -> mixout steps 36,32,...,0 over 10 ticks, never negative/wrap.
REQ-036 Ticks every cycle for 20 cycles -> 20 consecutive out_valid cycles, each mixout matching model; rst_n pulsed low mid-burst -> outputs 0 immediately, ramp_done=1, no out_valid until next tick.
REQ-037 Parameter sweep NUM_CH=1,VOL_W=8,OUT_W=8 and NUM_CH=8,VOL_W=4,OUT_W=8 -> mixout matches REQ-022/023 reference model on random stimulus.
